// File: rtl/x_reg_streamer_if.sv
// Output word stream from the X register streamer toward the systolic-array edge.
interface x_reg_streamer_if #(parameter int DATA_W = 16);
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  modport master (output m_valid, m_data, m_last, input m_ready);
  modport slave  (input m_valid, m_data, m_last, output m_ready);
endinterface

// File: rtl/x_reg_streamer.sv
// Walks a window of X register indices, one registered read per cycle, and streams the words out
// through a 2-entry buffer. Optional descending walk: define X_STREAM_REVERSE_EN (adds input rev).
module x_reg_streamer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [IDX_W-1:0]  base,
  input  logic [IDX_W:0]    len,
`ifdef X_STREAM_REVERSE_EN
  input  logic              rev,
`endif
  output logic              busy,
  output logic              done,
  output logic              xr_en,
  output logic              xr_write,
  output logic [IDX_W-1:0]  xr_idx,
  input  logic [DATA_W-1:0] xr_dout,
  x_reg_streamer_if.master  m
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } ent_t;

  localparam logic [IDX_W:0]   DEPTH_L = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] IMAX    = IDX_W'(DEPTH-1);

  state_t           state_q, state_d;
  logic [IDX_W:0]   rem_q, rem_d, len_clamp;
  logic [IDX_W-1:0] idx_d;
  logic             dir_q, dir_d, dir_in;
  logic             issue, last_d, busy_d, done_d;
  logic             xr_last_q, cap_vld_q, cap_last_q, cap, pop;
  logic [1:0]       occ_q;
  logic [2:0]       pend;
  ent_t             head_q, tail_q, new_w;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i, input logic d);
    if (d) return (i == '0)   ? IMAX : i - 1'b1;
    else   return (i == IMAX) ? '0   : i + 1'b1;
  endfunction

`ifdef X_STREAM_REVERSE_EN
  assign dir_in = rev;
`else
  assign dir_in = 1'b0;
`endif

  assign xr_write  = 1'b0;
  assign len_clamp = (len > DEPTH_L) ? DEPTH_L : len;
  assign m.m_valid = (occ_q != 2'd0);
  assign m.m_data  = head_q.data;
  assign m.m_last  = head_q.last;
  assign pop       = m.m_valid & m.m_ready;
  // The RF holds dout while en is low, so an uncaptured word simply waits there when the buffer is full.
  assign cap       = cap_vld_q & ~((occ_q == 2'd2) & ~pop);
  assign new_w     = '{last: cap_last_q, data: xr_dout};
  // Words already committed: buffer, held RF data and the read on the bus; a new read needs one of 3 slots.
  assign pend      = {1'b0, occ_q} + {2'b00, cap_vld_q} + {2'b00, xr_en} - {2'b00, pop};

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    idx_d   = xr_idx;
    issue   = 1'b0;
    last_d  = 1'b0;
    busy_d  = busy;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        if (len == '0) begin
          done_d = 1'b1;
        end else begin
          issue   = 1'b1;
          idx_d   = base;
          dir_d   = dir_in;
          rem_d   = len_clamp - 1'b1;
          last_d  = (len_clamp == 1);
          busy_d  = 1'b1;
          state_d = (len_clamp == 1) ? DRAIN : RUN;
        end
      end
      RUN: if (rem_q != '0 && pend < 3'd3) begin
        issue  = 1'b1;
        idx_d  = next_idx(xr_idx, dir_q);
        rem_d  = rem_q - 1'b1;
        last_d = (rem_q == 1);
        if (rem_q == 1) state_d = DRAIN;
      end
      DRAIN: if (pop && m.m_last) begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      dir_q      <= 1'b0;
      xr_idx     <= '0;
      xr_en      <= 1'b0;
      xr_last_q  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cap_vld_q  <= 1'b0;
      cap_last_q <= 1'b0;
      occ_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      dir_q     <= dir_d;
      xr_idx    <= idx_d;
      xr_en     <= issue;
      xr_last_q <= last_d;
      busy      <= busy_d;
      done      <= done_d;
      cap_vld_q <= xr_en | (cap_vld_q & ~cap);
      if (xr_en) cap_last_q <= xr_last_q;
      case ({cap, pop})
        2'b10: begin
          if (occ_q == 2'd0) head_q <= new_w;
          else               tail_q <= new_w;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          head_q <= tail_q;
          occ_q  <= occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) head_q <= new_w;
          else begin
            head_q <= tail_q;
            tail_q <= new_w;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_x_reg_streamer.sv
// Bench for x_reg_streamer: vector table of commands plus a reset/abort sequence, scoreboarded stream.
module tb_x_reg_streamer;

  typedef struct packed {
    logic        last;
    logic [15:0] data;
  } exp_t;

  typedef struct {
    int base;
    int len;
    bit rev;
    int mode;
    int exp_cycles;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  base = '0;
  logic [5:0]  len = '0;
`ifdef X_STREAM_REVERSE_EN
  logic        rev = 1'b0;
`endif
  logic        busy, done, xr_en, xr_write;
  logic [4:0]  xr_idx;
  logic [15:0] xr_dout = '0;
  logic [15:0] mem [32];

  x_reg_streamer_if #(.DATA_W(16)) mif ();

  x_reg_streamer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base(base), .len(len),
`ifdef X_STREAM_REVERSE_EN
    .rev(rev),
`endif
    .busy(busy), .done(done), .xr_en(xr_en), .xr_write(xr_write),
    .xr_idx(xr_idx), .xr_dout(xr_dout), .m(mif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (xr_en && !xr_write) xr_dout <= mem[xr_idx];

  int   errors = 0, checks = 0;
  int   words_seen = 0, xr_en_cnt = 0;
  exp_t exp_q[$];
  exp_t mon_e, prev_w;
  bit   prev_stall = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (xr_en) xr_en_cnt++;
      if (prev_stall) begin
        chk("stall_valid", int'(mif.m_valid), 1);
        chk("stall_word", int'({mif.m_last, mif.m_data}), int'(prev_w));
      end
      if (mif.m_valid && mif.m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_word: got data %0d, expected no word", mif.m_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("data", int'(mif.m_data), int'(mon_e.data));
          chk("last", int'(mif.m_last), int'(mon_e.last));
        end
        words_seen++;
      end
      prev_stall = mif.m_valid & ~mif.m_ready;
      prev_w     = {mif.m_last, mif.m_data};
    end
  end

  function automatic logic ready_pat(input int mode, input int cyc);
    case (mode)
      1:       return (cyc % 3) != 2;
      2:       return 1'($urandom_range(0, 1));
      3:       return cyc >= 10;
      default: return 1'b1;
    endcase
  endfunction

  task automatic push_exp(input vec_t v, output int n);
    int idx;
    n = (v.len > 32) ? 32 : v.len;
    for (int i = 0; i < n; i++) begin
      idx = v.rev ? (((v.base - i) % 32) + 32) % 32 : (v.base + i) % 32;
      exp_q.push_back('{last: (i == n - 1), data: 16'(idx + 1)});
    end
  endtask

  // Entered and left at #1 after a rising edge.
  task automatic run_cmd(input vec_t v);
    int n, cyc, first_v, seen0, en0;
    push_exp(v, n);
    seen0 = words_seen;
    en0   = xr_en_cnt;
    mif.m_ready = ready_pat(v.mode, 0);
    base  = 5'(v.base);
    len   = 6'(v.len);
`ifdef X_STREAM_REVERSE_EN
    rev   = v.rev;
`endif
    start = 1'b1;
    cyc = 0;
    first_v = -1;
    forever begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      if (cyc == 1) begin
        chk("busy_after_start", int'(busy), int'(n != 0));
        chk("xr_write", int'(xr_write), 0);
      end
      if (first_v < 0 && mif.m_valid) first_v = cyc;
      if (v.mode == 3 && cyc == 9) chk("reads_halted_in_stall", int'(xr_en), 0);
      if (done) break;
      if (cyc > 400) begin
        checks++;
        errors++;
        $display("FAIL done_timeout: no done after %0d cycles (base %0d len %0d)", cyc, v.base, v.len);
        break;
      end
      mif.m_ready = ready_pat(v.mode, cyc);
    end
    chk("busy_at_done", int'(busy), 0);
    if (v.exp_cycles >= 0) chk("cycles_to_done", cyc, v.exp_cycles);
    chk("first_valid_cycle", first_v, (n > 0) ? 3 : -1);
    chk("word_count", words_seen - seen0, n);
    chk("reads_issued", xr_en_cnt - en0, n);
    chk("scoreboard_empty", exp_q.size(), 0);
    @(posedge clk); #1;
    chk("done_one_cycle", int'(done), 0);
    exp_q.delete();
  endtask

  vec_t vecs[9];
  int   nvec;

  initial begin
    int cyc, seen0, n;
    vec_t rv;
    vecs[0] = '{base: 0,  len: 32, rev: 0, mode: 0, exp_cycles: 35};
    vecs[1] = '{base: 28, len: 8,  rev: 0, mode: 0, exp_cycles: 11};
    vecs[2] = '{base: 0,  len: 32, rev: 0, mode: 1, exp_cycles: -1};
    vecs[3] = '{base: 9,  len: 0,  rev: 0, mode: 0, exp_cycles: 1};
    vecs[4] = '{base: 0,  len: 40, rev: 0, mode: 0, exp_cycles: 35};
    vecs[5] = '{base: 17, len: 5,  rev: 0, mode: 2, exp_cycles: -1};
    vecs[6] = '{base: 3,  len: 6,  rev: 0, mode: 3, exp_cycles: -1};
    vecs[7] = '{base: 31, len: 1,  rev: 0, mode: 0, exp_cycles: 4};
    nvec = 8;
`ifdef X_STREAM_REVERSE_EN
    vecs[8] = '{base: 2,  len: 4,  rev: 1, mode: 0, exp_cycles: 7};
    nvec = 9;
`endif
    for (int i = 0; i < 32; i++) mem[i] = 16'(i + 1);
    mif.m_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_xr_en", int'(xr_en), 0);
    chk("rst_xr_write", int'(xr_write), 0);
    chk("rst_xr_idx", int'(xr_idx), 0);
    chk("rst_m_valid", int'(mif.m_valid), 0);
    chk("rst_m_data", int'(mif.m_data), 0);
    chk("rst_m_last", int'(mif.m_last), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < nvec; i++) run_cmd(vecs[i]);

    // Second start mid-command must be ignored; reset after word 5 aborts without done.
    rv = '{base: 0, len: 32, rev: 0, mode: 0, exp_cycles: -1};
    push_exp(rv, n);
    seen0 = words_seen;
    mif.m_ready = 1'b1;
    base = 5'd0;
    len  = 6'd32;
    start = 1'b1;
    cyc = 0;
    while (words_seen - seen0 < 5 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      start = (cyc == 2);
      if (cyc == 2) begin
        base = 5'd10;
        len  = 6'd3;
      end
    end
    if (cyc >= 60) begin
      checks++;
      errors++;
      $display("FAIL abort_timeout: only %0d words before limit", words_seen - seen0);
    end
    start = 1'b0;
    chk("busy_before_abort", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_xr_en", int'(xr_en), 0);
    chk("abort_xr_idx", int'(xr_idx), 0);
    chk("abort_m_valid", int'(mif.m_valid), 0);
    chk("abort_m_data", int'(mif.m_data), 0);
    chk("abort_m_last", int'(mif.m_last), 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("no_done_after_abort", int'(done), 0);
      chk("no_valid_after_abort", int'(mif.m_valid), 0);
    end
    rv = '{base: 5, len: 4, rev: 0, mode: 0, exp_cycles: 7};
    run_cmd(rv);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
